mag_window_stats: RTL and testbench

- Downstream consumer of the pipelined fixed-point magnitude stage, which has a fixed 17-cycle latency and no valid signal.
- Re-aligns a source-side valid strobe to the magnitude output by delaying it through a shift register.
- Collects non-overlapping windows of 2^LOG2_WIN magnitude samples and reports per window: peak, peak index, truncated mean and count of samples over a threshold.
- Results are returned through a registered valid/ready output buffer.

---
 rtl/mag_window_stats.sv | 171 +++++++++++++++++
 tb/tb_mag_window_stats.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mag_window_stats.sv
// Windowed statistics over the upstream magnitude stream: re-aligns the source valid to the
// fixed-latency magnitude output, then reports peak/index/mean/over-count per window.
module mag_window_stats #(
  parameter int unsigned M        = 37,
  parameter int unsigned PIPE_LAT = 17,
  parameter int unsigned LOG2_WIN = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                src_vld,
  input  logic [M-1:0]        mag,
  input  logic [M-1:0]        thresh,
  input  logic                clr,
  output logic [M-1:0]        out_peak,
  output logic [LOG2_WIN-1:0] out_idx,
  output logic [M-1:0]        out_mean,
  output logic [LOG2_WIN:0]   out_over,
  output logic                out_vld,
  input  logic                out_rdy,
  output logic [7:0]          drop_cnt
);

  localparam int unsigned SW = M + LOG2_WIN;
  localparam int unsigned OW = LOG2_WIN + 1;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  // Valid alignment
  logic [PIPE_LAT-1:0] sreg_q;
  logic                accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
    end else begin
      sreg_q <= {sreg_q[PIPE_LAT-2:0], src_vld};
    end
  end

  assign accept = sreg_q[PIPE_LAT-1];

  // Running window accumulators
  logic [LOG2_WIN-1:0] samp_cnt_q, samp_cnt_d;
  logic [M-1:0]        run_peak_q, nx_peak;
  logic [LOG2_WIN-1:0] run_idx_q, nx_idx;
  logic [SW-1:0]       run_sum_q, nx_sum;
  logic [OW-1:0]       run_over_q, nx_over;
  logic                complete;
  logic                first;
  logic                gt_thresh;
  logic                gt_peak;

  assign complete  = accept && (samp_cnt_q == {LOG2_WIN{1'b1}});
  // A clr that lands on the completing sample loses to completion.
  assign first     = (samp_cnt_q == '0) || (clr && !complete);
  assign gt_thresh = mag > thresh;
  assign gt_peak   = mag > run_peak_q;

  always_comb begin
    nx_peak = run_peak_q;
    nx_idx  = run_idx_q;
    nx_sum  = run_sum_q;
    nx_over = run_over_q;
    if (first) begin
      nx_peak = mag;
      nx_idx  = '0;
      nx_sum  = SW'(mag);
      nx_over = OW'(gt_thresh);
    end else begin
      if (gt_peak) begin
        nx_peak = mag;
        nx_idx  = samp_cnt_q;
      end
      nx_sum  = run_sum_q + SW'(mag);
      nx_over = run_over_q + OW'(gt_thresh);
    end
  end

  always_comb begin
    samp_cnt_d = samp_cnt_q;
    if (accept) begin
      samp_cnt_d = first ? LOG2_WIN'(1) : samp_cnt_q + LOG2_WIN'(1);
    end else if (clr) begin
      samp_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_cnt_q <= '0;
      run_peak_q <= '0;
      run_idx_q  <= '0;
      run_sum_q  <= '0;
      run_over_q <= '0;
    end else begin
      samp_cnt_q <= samp_cnt_d;
      if (accept) begin
        run_peak_q <= nx_peak;
        run_idx_q  <= nx_idx;
        run_sum_q  <= nx_sum;
        run_over_q <= nx_over;
      end
    end
  end

  // Output buffer
  state_e              state_q, state_d;
  logic                load;
  logic                drop;
  logic [M-1:0]        peak_q;
  logic [LOG2_WIN-1:0] idx_q;
  logic [M-1:0]        mean_q;
  logic [OW-1:0]       over_q;
  logic [7:0]          drop_q;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      StEmpty: begin
        if (complete) begin
          load    = 1'b1;
          state_d = StFull;
        end
      end
      StFull: begin
        if (complete) begin
          if (out_rdy) begin
            load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (out_rdy) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      peak_q  <= '0;
      idx_q   <= '0;
      mean_q  <= '0;
      over_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        peak_q <= nx_peak;
        idx_q  <= nx_idx;
        mean_q <= nx_sum[SW-1:LOG2_WIN];
        over_q <= nx_over;
      end
      if (drop && (drop_q != 8'hff)) begin
        drop_q <= drop_q + 8'd1;
      end
    end
  end

  assign out_vld  = (state_q == StFull);
  assign out_peak = peak_q;
  assign out_idx  = idx_q;
  assign out_mean = mean_q;
  assign out_over = over_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_mag_window_stats.sv
// Directed bench for mag_window_stats: a table of complete windows plus hand-timed sequences
// for backpressure, clr alignment, asynchronous reset and drop counter saturation.
module tb_mag_window_stats;

  localparam int unsigned M        = 37;
  localparam int unsigned PIPE_LAT = 17;
  localparam int unsigned LOG2_WIN = 4;
  localparam logic [M-1:0] JUNK    = 37'h15_5555_5555;
  localparam logic [M-1:0] MAXV    = {M{1'b1}};

  logic                clk = 1'b0;
  logic                rst_n;
  logic                src_vld;
  logic [M-1:0]        src_mag;
  logic [M-1:0]        mag;
  logic [M-1:0]        thresh;
  logic                clr;
  logic [M-1:0]        out_peak;
  logic [LOG2_WIN-1:0] out_idx;
  logic [M-1:0]        out_mean;
  logic [LOG2_WIN:0]   out_over;
  logic                out_vld;
  logic                out_rdy;
  logic [7:0]          drop_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Upstream stand-in: magnitude appears PIPE_LAT cycles after its src_vld; junk otherwise.
  logic [PIPE_LAT-1:0]        pv = '0;
  logic [PIPE_LAT-1:0][M-1:0] pm = '0;
  always @(posedge clk) begin
    pv <= {pv[PIPE_LAT-2:0], src_vld};
    pm <= {pm[PIPE_LAT-2:0], src_mag};
  end
  assign mag = pv[PIPE_LAT-1] ? pm[PIPE_LAT-1] : JUNK;

  mag_window_stats #(
    .M        (M),
    .PIPE_LAT (PIPE_LAT),
    .LOG2_WIN (LOG2_WIN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_vld  (src_vld),
    .mag      (mag),
    .thresh   (thresh),
    .clr      (clr),
    .out_peak (out_peak),
    .out_idx  (out_idx),
    .out_mean (out_mean),
    .out_over (out_over),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .drop_cnt (drop_cnt)
  );

  typedef struct packed {
    logic [15:0][M-1:0] mags;
    logic [M-1:0]       th;
    logic [M-1:0]       peak;
    logic [3:0]         idx;
    logic [M-1:0]       mean;
    logic [4:0]         over;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_burst(input int n, input logic [M-1:0] v);
    for (int i = 0; i < n; i++) begin
      src_vld = 1'b1;
      src_mag = v;
      @(posedge clk); #1;
    end
    src_vld = 1'b0;
  endtask

  task automatic send_vec(input vec_t vv, input bit gap);
    for (int i = 0; i < 16; i++) begin
      src_vld = 1'b1;
      src_mag = vv.mags[i];
      @(posedge clk); #1;
      if (gap && i != 15) begin
        src_vld = 1'b0;
        @(posedge clk); #1;
      end
    end
    src_vld = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!out_vld && n < 80);
    check("out_vld rise", 64'(out_vld), 64'd1);
  endtask

  // clr pulses in the cycle the k-th sample of the combined stream is accepted.
  task automatic burst_clr(input int n1, input logic [M-1:0] v1, input int n2,
                           input logic [M-1:0] v2, input int k);
    fork
      begin
        send_burst(n1, v1);
        send_burst(n2, v2);
      end
      begin
        repeat (k + PIPE_LAT) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
      end
    join
  endtask

  task automatic count_vld(input int cycles, output int seen);
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (out_vld) seen++;
    end
  endtask

  initial begin
    int n;
    int seen;
    rst_n   = 1'b0;
    src_vld = 1'b0;
    src_mag = '0;
    thresh  = '0;
    clr     = 1'b0;
    out_rdy = 1'b1;

    for (int v = 0; v < 6; v++) vecs[v] = '0;
    for (int i = 0; i < 16; i++) begin
      vecs[0].mags[i] = M'(i + 1);
      vecs[1].mags[i] = M'(5);
      vecs[2].mags[i] = (i == 3 || i == 7) ? M'(9) : M'(5);
      vecs[3].mags[i] = M'(16 - i);
      vecs[4].mags[i] = MAXV;
      vecs[5].mags[i] = (i == 10) ? M'(1000) : M'(i);
    end
    vecs[0].th = M'(10);  vecs[0].peak = M'(16);   vecs[0].idx = 4'd15;
    vecs[0].mean = M'(8); vecs[0].over = 5'd6;
    vecs[1].th = M'(5);   vecs[1].peak = M'(5);    vecs[1].idx = 4'd0;
    vecs[1].mean = M'(5); vecs[1].over = 5'd0;
    vecs[2].th = M'(5);   vecs[2].peak = M'(9);    vecs[2].idx = 4'd3;
    vecs[2].mean = M'(5); vecs[2].over = 5'd2;
    vecs[3].th = M'(0);   vecs[3].peak = M'(16);   vecs[3].idx = 4'd0;
    vecs[3].mean = M'(8); vecs[3].over = 5'd16;
    vecs[4].th = MAXV - M'(1); vecs[4].peak = MAXV; vecs[4].idx = 4'd0;
    vecs[4].mean = MAXV;  vecs[4].over = 5'd16;
    vecs[5].th = M'(500); vecs[5].peak = M'(1000); vecs[5].idx = 4'd10;
    vecs[5].mean = M'(69); vecs[5].over = 5'd1;

    #12;
    check("reset out_vld", 64'(out_vld), 64'd0);
    check("reset out_peak", 64'(out_peak), 64'd0);
    check("reset out_idx", 64'(out_idx), 64'd0);
    check("reset out_mean", 64'(out_mean), 64'd0);
    check("reset out_over", 64'(out_over), 64'd0);
    check("reset drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Table of complete windows; odd entries have idle cycles between samples.
    for (int v = 0; v < 6; v++) begin
      thresh  = vecs[v].th;
      out_rdy = 1'b1;
      send_vec(vecs[v], v[0]);
      wait_result(n);
      check($sformatf("vec%0d latency", v), 64'(n), 64'(PIPE_LAT));
      check($sformatf("vec%0d peak", v), 64'(out_peak), 64'(vecs[v].peak));
      check($sformatf("vec%0d idx", v), 64'(out_idx), 64'(vecs[v].idx));
      check($sformatf("vec%0d mean", v), 64'(out_mean), 64'(vecs[v].mean));
      check($sformatf("vec%0d over", v), 64'(out_over), 64'(vecs[v].over));
      @(posedge clk); #1;
      check($sformatf("vec%0d vld one cycle", v), 64'(out_vld), 64'd0);
      repeat (3) @(posedge clk);
      #1;
    end

    // Backpressure: second window dropped, third loaded on a coincident out_rdy.
    out_rdy = 1'b0;
    thresh  = M'(10);
    send_vec(vecs[0], 1'b0);
    send_vec(vecs[1], 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check("bp held vld", 64'(out_vld), 64'd1);
    check("bp held peak", 64'(out_peak), 64'd16);
    check("bp held idx", 64'(out_idx), 64'd15);
    check("bp held over", 64'(out_over), 64'd6);
    check("bp drop_cnt", 64'(drop_cnt), 64'd1);
    send_vec(vecs[2], 1'b0);
    repeat (PIPE_LAT - 1) @(posedge clk);
    #1 out_rdy = 1'b1;
    @(posedge clk); #1 out_rdy = 1'b0;
    check("bp reload vld", 64'(out_vld), 64'd1);
    check("bp reload peak", 64'(out_peak), 64'd9);
    check("bp reload idx", 64'(out_idx), 64'd3);
    check("bp reload mean", 64'(out_mean), 64'd5);
    check("bp reload over", 64'(out_over), 64'd0);
    check("bp drop_cnt kept", 64'(drop_cnt), 64'd1);
    out_rdy = 1'b1;
    @(posedge clk); #1;
    check("bp drained", 64'(out_vld), 64'd0);

    // clr after 7 samples, landing on the first of sixteen 2s.
    out_rdy = 1'b0;
    thresh  = M'(0);
    burst_clr(7, M'(100), 16, M'(2), 7);
    wait_result(n);
    check("clr mid peak", 64'(out_peak), 64'd2);
    check("clr mid idx", 64'(out_idx), 64'd0);
    check("clr mid mean", 64'(out_mean), 64'd2);
    check("clr mid over", 64'(out_over), 64'd16);
    out_rdy = 1'b1;
    @(posedge clk); #1;
    count_vld(30, seen);
    check("clr mid single result", 64'(seen), 64'd0);

    // clr on the completing sample: window still delivered, next window starts clean.
    out_rdy = 1'b0;
    burst_clr(0, M'(0), 16, M'(3), 15);
    wait_result(n);
    check("clr last mean", 64'(out_mean), 64'd3);
    check("clr last peak", 64'(out_peak), 64'd3);
    out_rdy = 1'b1;
    @(posedge clk); #1;
    check("clr last drained", 64'(out_vld), 64'd0);
    send_burst(16, M'(4));
    wait_result(n);
    check("after clr latency", 64'(n), 64'(PIPE_LAT));
    check("after clr mean", 64'(out_mean), 64'd4);
    @(posedge clk); #1;

    // Asynchronous reset with a held result and a partial window in flight.
    out_rdy = 1'b0;
    send_burst(16, M'(7));
    wait_result(n);
    send_burst(8, M'(200));
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst out_vld", 64'(out_vld), 64'd0);
    check("rst out_peak", 64'(out_peak), 64'd0);
    check("rst out_idx", 64'(out_idx), 64'd0);
    check("rst out_mean", 64'(out_mean), 64'd0);
    check("rst out_over", 64'(out_over), 64'd0);
    check("rst drop_cnt", 64'(drop_cnt), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    out_rdy = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    send_burst(15, M'(7));
    count_vld(25, seen);
    check("rst partial no result", 64'(seen), 64'd0);
    send_burst(1, M'(7));
    wait_result(n);
    check("rst fresh latency", 64'(n), 64'(PIPE_LAT));
    check("rst fresh mean", 64'(out_mean), 64'd7);
    check("rst fresh peak", 64'(out_peak), 64'd7);
    @(posedge clk); #1;

    // drop_cnt saturation: 1 held + 256 dropped windows.
    out_rdy = 1'b0;
    send_burst(16 * 257, M'(1));
    repeat (20) @(posedge clk);
    #1;
    check("sat drop_cnt", 64'(drop_cnt), 64'd255);
    check("sat vld", 64'(out_vld), 64'd1);
    check("sat peak", 64'(out_peak), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
